// File: rtl/sevenseg_decoder_if.sv
// Signal bundle between a scanned seven-segment display and its decoder.
// The master drives segment/select lines; the slave returns the decoded digits.
interface sevenseg_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              in_leds;
  logic [NUM_DIGITS-1:0]   in_sel;
  logic [4*NUM_DIGITS-1:0] out_digits;
  logic [NUM_DIGITS-1:0]   out_valid;
  logic [NUM_DIGITS-1:0]   out_err;
  logic                    out_update;
  logic [2:0]              out_idx;

  modport master (
    output in_leds, in_sel,
    input  out_digits, out_valid, out_err, out_update, out_idx
  );

  modport slave (
    input  in_leds, in_sel,
    output out_digits, out_valid, out_err, out_update, out_idx
  );
endinterface

// File: rtl/sevenseg_decoder.sv
// Recovers hex digits from a multiplexed seven-segment display: samples segment/select lines,
// waits for a stable one-hot sample, then commits the decoded pattern to that digit position.

module sevenseg_slot (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       wr,
  input  logic       wr_hit,
  input  logic       wr_blank,
  input  logic [3:0] wr_digit,
  output logic [3:0] digit,
  output logic       valid,
  output logic       err
);
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      digit <= 4'h0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else if (wr) begin
      // blank and undecodable patterns keep the last good digit value
      if (wr_hit) digit <= wr_digit;
      valid <= wr_hit;
      err   <= !wr_hit && !wr_blank;
    end
  end
endmodule

module sevenseg_decoder #(
  parameter bit ZERO_IS_ON        = 1'b0,
  parameter bit INVERSE_NUMBERING = 1'b0,
  parameter int NUM_DIGITS        = 4,
  parameter int STABLE_CYCLES     = 4
) (
  input logic               in_clk,
  input logic               in_rst,
  sevenseg_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT, HOLD} state_t;

  typedef struct packed {
    logic       hit;
    logic       blank;
    logic [3:0] digit;
  } dec_t;

  localparam logic [6:0] TAB_A [16] = '{
    7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33, 7'h5b, 7'h5f, 7'h70,
    7'h7f, 7'h7b, 7'h77, 7'h1f, 7'h4e, 7'h3d, 7'h4f, 7'h47
  };
  localparam logic [6:0] TAB_B [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
  };
  localparam logic [7:0] CNT_DONE = 8'(STABLE_CYCLES - 1);

  function automatic dec_t decode(input logic [6:0] pat);
    dec_t r;
    r       = '0;
    r.blank = (pat == 7'h00);
    for (int i = 0; i < 16; i++) begin
      if (pat == (INVERSE_NUMBERING ? TAB_B[i] : TAB_A[i])) begin
        r.hit   = 1'b1;
        r.digit = 4'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] sel_index(input logic [NUM_DIGITS-1:0] sel);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (sel[i]) r = 3'(i);
    return r;
  endfunction

  logic [6:0]                 samp_leds, prev_leds;
  logic [NUM_DIGITS-1:0]      samp_sel, prev_sel;
  logic [7:0]                 cnt;
  state_t                     state, nxt;
  logic                       changed, one_hot, update;
  dec_t                       cdec;
  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [NUM_DIGITS-1:0]      valid, err;

  assign changed = {samp_leds, samp_sel} != {prev_leds, prev_sel};
  assign one_hot = $onehot(samp_sel);

  // Sample pipeline and stability counter; prev_* lags samp_* by one cycle.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      samp_leds <= '0;
      samp_sel  <= '0;
      prev_leds <= '0;
      prev_sel  <= '0;
      cnt       <= '0;
    end else begin
      samp_leds <= ZERO_IS_ON ? ~bus.in_leds : bus.in_leds;
      samp_sel  <= bus.in_sel;
      prev_leds <= samp_leds;
      prev_sel  <= samp_sel;
      if (changed)             cnt <= '0;
      else if (cnt != 8'hff)   cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (one_hot) nxt = SETTLE;
      SETTLE: begin
        if (!one_hot)             nxt = IDLE;
        else if (changed)         nxt = SETTLE;
        else if (cnt >= CNT_DONE) nxt = COMMIT;
      end
      // A sample arriving during the commit cycle would be invisible from HOLD
      // (prev catches up with it), so it is picked up here instead.
      COMMIT: begin
        if (changed) nxt = one_hot ? SETTLE : IDLE;
        else         nxt = HOLD;
      end
      HOLD:   if (changed) nxt = one_hot ? SETTLE : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // In COMMIT, prev_* still holds the sample that was proven stable.
  assign cdec           = decode(prev_leds);
  assign update         = (state == COMMIT) && !in_rst;
  assign bus.out_update = update;
  assign bus.out_idx    = update ? sel_index(prev_sel) : 3'd0;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
    sevenseg_slot u_slot (
      .in_clk   (in_clk),
      .in_rst   (in_rst),
      .wr       (update && prev_sel[g]),
      .wr_hit   (cdec.hit),
      .wr_blank (cdec.blank),
      .wr_digit (cdec.digit),
      .digit    (digits[g]),
      .valid    (valid[g]),
      .err      (err[g])
    );
  end

  assign bus.out_digits = digits;
  assign bus.out_valid  = valid;
  assign bus.out_err    = err;
endmodule

// File: tb/tb_sevenseg_decoder.sv
// Bench for sevenseg_decoder: directed scenarios plus random scans against a run-length model.
module tb_sevenseg_decoder;
  localparam int ND = 4;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sevenseg_decoder_if #(.NUM_DIGITS(ND)) bus0 ();
  sevenseg_decoder_if #(.NUM_DIGITS(ND)) bus1 ();

  sevenseg_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut0 (
    .in_clk(clk), .in_rst(rst), .bus(bus0)
  );
  sevenseg_decoder #(.ZERO_IS_ON(1'b1), .INVERSE_NUMBERING(1'b1),
                     .NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut1 (
    .in_clk(clk), .in_rst(rst), .bus(bus1)
  );

  // Model: a pair (sel, leds) seen on SC+1 consecutive edges strobes once on the next edge,
  // and the position is written one edge after the strobe.
  logic [6:0] tab_a [16] = '{7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33, 7'h5b, 7'h5f, 7'h70,
                             7'h7f, 7'h7b, 7'h77, 7'h1f, 7'h4e, 7'h3d, 7'h4f, 7'h47};
  logic [6:0]  m_last_leds = '0;
  logic [3:0]  m_last_sel  = '0;
  int          m_run       = 1;
  bit          m_done      = 1'b0;
  logic        m_update    = 1'b0;
  logic [2:0]  m_idx       = '0;
  logic [6:0]  m_wr_leds   = '0;
  logic [15:0] m_digits    = '0;
  logic [3:0]  m_valid     = '0;
  logic [3:0]  m_err       = '0;

  task automatic model_step();
    int d;
    if (rst) begin
      m_last_leds = '0; m_last_sel = '0; m_run = 1; m_done = 1'b0;
      m_update = 1'b0; m_idx = '0; m_digits = '0; m_valid = '0; m_err = '0;
      return;
    end
    if (m_update) begin
      d = -1;
      for (int i = 0; i < 16; i++) if (tab_a[i] == m_wr_leds) d = i;
      if (d >= 0) begin
        m_digits[m_idx*4 +: 4] = 4'(d); m_valid[m_idx] = 1'b1; m_err[m_idx] = 1'b0;
      end else begin
        m_valid[m_idx] = 1'b0; m_err[m_idx] = (m_wr_leds != 7'h00);
      end
    end
    m_update = (m_run >= SC + 1) && ($countones(m_last_sel) == 1) && !m_done;
    if (m_update) begin
      m_done    = 1'b1;
      m_wr_leds = m_last_leds;
      for (int i = 0; i < 4; i++) if (m_last_sel[i]) m_idx = 3'(i);
    end
    if (bus0.in_leds == m_last_leds && bus0.in_sel == m_last_sel) m_run++;
    else begin
      m_run = 1; m_done = 1'b0; m_last_leds = bus0.in_leds; m_last_sel = bus0.in_sel;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus0.out_update !== 1'b0) begin errors++; $display("FAIL rst_update got=%b exp=0", bus0.out_update); end
    checks++; if (bus0.out_idx !== 3'd0) begin errors++; $display("FAIL rst_idx got=%0d exp=0", bus0.out_idx); end
    checks++; if (bus0.out_digits !== 16'h0) begin errors++; $display("FAIL rst_digits got=%h exp=0", bus0.out_digits); end
    checks++; if (bus0.out_valid !== 4'h0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus0.out_valid); end
    checks++; if (bus0.out_err !== 4'h0) begin errors++; $display("FAIL rst_err got=%b exp=0", bus0.out_err); end
    checks++; if ({bus1.out_update, bus1.out_digits, bus1.out_valid, bus1.out_err} !== '0) begin
      errors++; $display("FAIL rst_dut1 got=%h exp=0", {bus1.out_update, bus1.out_digits, bus1.out_valid, bus1.out_err});
    end
  endtask

  task automatic test_latency();
    int first = -1;
    int n = 0;
    logic [2:0] sidx = '0;
    rst = 1'b0;
    bus0.in_sel = 4'b0001; bus0.in_leds = 7'h6d;
    // k = 1 is the first sampling edge
    for (int k = 1; k <= 305; k++) begin
      tick();
      checks++; if (bus0.out_update !== m_update) begin errors++; $display("FAIL lat_update k=%0d got=%b exp=%b", k, bus0.out_update, m_update); end
      if (bus0.out_update === 1'b1) begin n++; if (first < 0) begin first = k; sidx = bus0.out_idx; end end
    end
    checks++; if (first != SC + 2) begin errors++; $display("FAIL lat_edge got=%0d exp=%0d", first, SC + 2); end
    checks++; if (n != 1) begin errors++; $display("FAIL lat_count got=%0d exp=1", n); end
    checks++; if (sidx !== 3'd0) begin errors++; $display("FAIL lat_idx got=%0d exp=0", sidx); end
    checks++; if (bus0.out_digits[3:0] !== 4'h2 || bus0.out_valid[0] !== 1'b1) begin
      errors++; $display("FAIL lat_digit0 got=%h/%b exp=2/1", bus0.out_digits[3:0], bus0.out_valid[0]);
    end
  endtask

  task automatic test_alternate();
    int n = 0;
    bus0.in_sel = 4'b0010;
    for (int k = 0; k < 30; k++) begin
      bus0.in_leds = ((k / 3) % 2 == 0) ? 7'h30 : 7'h79;
      tick();
      if (bus0.out_update === 1'b1) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL alt_nostrobe got=%0d exp=0", n); end
    bus0.in_leds = 7'h79;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++; if (bus0.out_update !== m_update) begin errors++; $display("FAIL alt_update k=%0d got=%b exp=%b", k, bus0.out_update, m_update); end
      if (bus0.out_update === 1'b1) n++;
    end
    checks++; if (n != 1) begin errors++; $display("FAIL alt_hold_count got=%0d exp=1", n); end
    checks++; if (bus0.out_digits[7:4] !== 4'h3 || bus0.out_valid[1] !== 1'b1) begin
      errors++; $display("FAIL alt_digit1 got=%h/%b exp=3/1", bus0.out_digits[7:4], bus0.out_valid[1]);
    end
  endtask

  task automatic test_scan();
    logic [6:0] pats [4] = '{7'h30, 7'h6d, 7'h79, 7'h33};
    int n;
    for (int s = 0; s < 2; s++) begin
      n = 0;
      for (int p = 0; p < 4; p++) begin
        bus0.in_sel = 4'(1 << p); bus0.in_leds = pats[p];
        for (int k = 0; k < 8; k++) begin
          tick();
          checks++; if (bus0.out_update !== m_update) begin errors++; $display("FAIL scan_update s=%0d p=%0d got=%b exp=%b", s, p, bus0.out_update, m_update); end
          if (bus0.out_update === 1'b1) n++;
        end
      end
      checks++; if (n != 4) begin errors++; $display("FAIL scan_strobes s=%0d got=%0d exp=4", s, n); end
    end
    checks++; if (bus0.out_digits !== 16'h4321) begin errors++; $display("FAIL scan_digits got=%h exp=4321", bus0.out_digits); end
    checks++; if (bus0.out_valid !== 4'b1111 || bus0.out_err !== 4'b0000) begin
      errors++; $display("FAIL scan_flags got=%b/%b exp=1111/0000", bus0.out_valid, bus0.out_err);
    end
  endtask

  task automatic test_err_blank();
    int n = 0;
    bus0.in_sel = 4'b1000; bus0.in_leds = 7'h01;
    repeat (10) begin tick(); if (bus0.out_update === 1'b1) n++; end
    checks++; if (n != 1) begin errors++; $display("FAIL err_strobes got=%0d exp=1", n); end
    checks++; if (bus0.out_err[3] !== 1'b1 || bus0.out_valid[3] !== 1'b0 || bus0.out_digits[15:12] !== 4'h4) begin
      errors++; $display("FAIL err_set got=%b/%b/%h exp=1/0/4", bus0.out_err[3], bus0.out_valid[3], bus0.out_digits[15:12]);
    end
    bus0.in_leds = 7'h00;
    repeat (10) tick();
    checks++; if (bus0.out_err[3] !== 1'b0 || bus0.out_valid[3] !== 1'b0 || bus0.out_digits[15:12] !== 4'h4) begin
      errors++; $display("FAIL blank got=%b/%b/%h exp=0/0/4", bus0.out_err[3], bus0.out_valid[3], bus0.out_digits[15:12]);
    end
    n = 0;
    bus0.in_sel = 4'b0011; bus0.in_leds = 7'h30;
    repeat (20) begin tick(); if (bus0.out_update === 1'b1) n++; end
    checks++; if (n != 0) begin errors++; $display("FAIL multisel got=%0d exp=0", n); end
    checks++; if (bus0.out_digits !== 16'h4321 || bus0.out_valid !== 4'b0111) begin
      errors++; $display("FAIL multisel_state got=%h/%b exp=4321/0111", bus0.out_digits, bus0.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    bus0.in_sel = 4'b0000; bus0.in_leds = 7'h00;
    repeat (3) tick();
    bus0.in_sel = 4'b0001; bus0.in_leds = 7'h5b;
    for (int k = 1; k <= SC + 1; k++) begin
      tick();
      checks++; if (bus0.out_update !== 1'b0) begin errors++; $display("FAIL rmid_early k=%0d got=%b exp=0", k, bus0.out_update); end
    end
    rst = 1'b1;
    tick();
    checks++; if ({bus0.out_update, bus0.out_idx, bus0.out_digits, bus0.out_valid, bus0.out_err} !== '0) begin
      errors++; $display("FAIL rmid_cancel got=%h exp=0", {bus0.out_update, bus0.out_idx, bus0.out_digits, bus0.out_valid, bus0.out_err});
    end
    rst = 1'b0;
    for (int k = 1; k <= SC + 4; k++) begin
      tick();
      if (bus0.out_update === 1'b1 && first < 0) first = k;
    end
    checks++; if (first != SC + 2) begin errors++; $display("FAIL rmid_relatch got=%0d exp=%0d", first, SC + 2); end
    checks++; if (bus0.out_digits[3:0] !== 4'h5 || bus0.out_valid !== 4'b0001) begin
      errors++; $display("FAIL rmid_digit got=%h/%b exp=5/0001", bus0.out_digits[3:0], bus0.out_valid);
    end
  endtask

  task automatic test_inverse();
    logic [6:0] p = 7'h39;
    bit seen = 1'b0;
    logic [2:0] sidx = '0;
    bus1.in_sel = 4'b0100; bus1.in_leds = ~p;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (bus1.out_update === 1'b1) begin seen = 1'b1; sidx = bus1.out_idx; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL inv_timeout got=none exp=strobe"); end
    checks++; if (sidx !== 3'd2) begin errors++; $display("FAIL inv_idx got=%0d exp=2", sidx); end
    tick();
    checks++; if (bus1.out_digits[11:8] !== 4'hc || bus1.out_valid[2] !== 1'b1 || bus1.out_err[2] !== 1'b0) begin
      errors++; $display("FAIL inv_digit2 got=%h/%b/%b exp=c/1/0", bus1.out_digits[11:8], bus1.out_valid[2], bus1.out_err[2]);
    end
  endtask

  task automatic test_random();
    int r, len, cyc;
    cyc = 0;
    for (int seg = 0; seg < 200; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       bus0.in_sel = 4'(1 << $urandom_range(0, 3));
      else if (r == 6) bus0.in_sel = 4'b0000;
      else             bus0.in_sel = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 6)       bus0.in_leds = tab_a[$urandom_range(0, 15)];
      else if (r == 6) bus0.in_leds = 7'h00;
      else             bus0.in_leds = 7'($urandom);
      rst = ($urandom_range(0, 19) == 0);
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        tick();
        cyc++;
        rst = 1'b0;
        checks++; if (bus0.out_update !== m_update) begin errors++; $display("FAIL rnd_update cyc=%0d got=%b exp=%b", cyc, bus0.out_update, m_update); end
        if (m_update) begin
          checks++; if (bus0.out_idx !== m_idx) begin errors++; $display("FAIL rnd_idx cyc=%0d got=%0d exp=%0d", cyc, bus0.out_idx, m_idx); end
        end
        checks++; if ({bus0.out_digits, bus0.out_valid, bus0.out_err} !== {m_digits, m_valid, m_err}) begin
          errors++; $display("FAIL rnd_state cyc=%0d got=%h/%b/%b exp=%h/%b/%b", cyc,
                             bus0.out_digits, bus0.out_valid, bus0.out_err, m_digits, m_valid, m_err);
        end
      end
    end
  endtask

  initial begin
    bus0.in_leds = 7'h00; bus0.in_sel = 4'b0000;
    bus1.in_leds = 7'h7f; bus1.in_sel = 4'b0000;
    test_reset();
    test_latency();
    test_alternate();
    test_scan();
    test_err_blank();
    test_reset_mid();
    test_inverse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sevenseg_decoder.md
SEVENSEG_DECODER -- requirements
Module: sevenseg_decoder

Interface
REQ-001 The block SHALL have parameter ZERO_IS_ON, default 0: 1 = segment lines active-low (in_leds inverted before decoding).
REQ-002 The block SHALL have parameter INVERSE_NUMBERING, default 0: selects decode table B instead of table A (REQ-013).
REQ-003 The block SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digit positions, range 1..8.
REQ-004 The block SHALL have parameter STABLE_CYCLES, default 4: consecutive identical samples required before commit, range 2..255.
REQ-005 The block SHALL have port in_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port in_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port in_leds, input, 7 bits: segment lines g..a, bit 6 = a.
REQ-008 The block SHALL have port in_sel, input, NUM_DIGITS bits: active-high digit select, one-hot when a digit is driven.
REQ-009 The block SHALL have port out_digits, output, 4*NUM_DIGITS bits: decoded hex value per position, position i in bits [4i+3:4i].
REQ-010 The block SHALL have port out_valid, output, NUM_DIGITS bits: position holds a decoded digit.
REQ-011 The block SHALL have port out_err, output, NUM_DIGITS bits: last committed pattern of the position was not decodable.
REQ-012 The block SHALL have port out_update, output, 1 bit, plus port out_idx, output, 3 bits: out_update is a one-cycle commit strobe and out_idx is the position committed, valid while out_update = 1.

Function
REQ-013 The block SHALL use these decode tables, digits 0..f in order. Table A: 7e 30 6d 79 33 5b 5f 70 7f 7b 77 1f 4e 3d 4f 47. Table B: 3f 06 5b 4f 66 6d 7d 07 7f 6f 77 7c 39 5e 79 71.
REQ-014 The block SHALL register in_leds (after ZERO_IS_ON inversion) and in_sel every cycle; all decisions use the registered sample.
REQ-015 The block SHALL keep an 8-bit stability counter: cleared when the registered sample differs from the previous registered sample, otherwise incremented, saturating at 255.
REQ-016 The block SHALL implement states IDLE, SETTLE, COMMIT and HOLD.
REQ-017 In IDLE, the block SHALL go to SETTLE on the first sample with exactly one in_sel bit set; zero or multiple select bits keep it in IDLE.
REQ-018 In SETTLE, the block SHALL return to IDLE if the sample is not one-hot; if the sample changes, it SHALL restart the count and stay in SETTLE; when the counter reaches STABLE_CYCLES-1, it SHALL go to COMMIT.
REQ-019 In COMMIT (exactly one cycle), the block SHALL assert out_update, set out_idx to the select index and write position idx, then go to HOLD.
REQ-020 On a pattern match, the commit SHALL set digit = table index, valid = 1 and err = 0.
REQ-021 On a pattern of 7'h00 (blank), the commit SHALL leave the digit unchanged and set valid = 0 and err = 0.
REQ-022 On any other pattern, the commit SHALL leave the digit unchanged and set valid = 0 and err = 1.
REQ-023 In HOLD, the block SHALL make no further commit while the sample is unchanged; on a change it SHALL go to SETTLE if one-hot, else IDLE.
REQ-024 Latency: with the input constant from the first sampling edge, out_update SHALL be high in cycle STABLE_CYCLES+1 after that edge.
REQ-025 Positions other than idx SHALL be unaffected by a commit; out_digits, out_valid and out_err SHALL be registered and change only in COMMIT.
REQ-026 A stable input SHALL produce exactly one commit, with no re-commit on counter saturation.

Reset
REQ-027 While in_rst = 1, the block SHALL set state to IDLE, the counter and registered sample to 0, out_digits, out_valid and out_err to all 0, and out_update and out_idx to 0.
REQ-028 If reset is asserted during SETTLE or COMMIT, the block SHALL cancel the pending commit, produce no out_update in that cycle, and suppress any commit until a fresh stable sample after reset.

Verification
REQ-029 With defaults, in_sel=0001 and in_leds=7'h6d held: out_update high exactly 5 cycles after the first sampling edge, out_idx=0, digit0=2, valid0=1; no further strobe over 300 cycles.
REQ-030 With INVERSE_NUMBERING=1 and ZERO_IS_ON=1, in_sel=0100 and in_leds=~7'h39: commit idx=2, digit2=c, valid2=1, err2=0.
REQ-031 With in_leds alternating 7'h30 and 7'h79 every 3 cycles on in_sel=0010: no out_update; then held at 7'h79: digit1=3 committed.
REQ-032 In a scan loop digits 0..3 showing 1,2,3,4 with 8 cycles each: four strobes per scan, out_digits=16'h4321, out_valid=1111.
REQ-033 Pattern 7'h01 on position 3 sets err3=1 and valid3=0; later pattern 7'h00 on position 3 gives err3=0, valid3=0 with digit3 unchanged; in_sel=0011 produces no commit.
REQ-034 Reset pulsed in the cycle before the expected strobe: no strobe, all outputs 0; after release, the commit occurs STABLE_CYCLES+1 cycles later.
